// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI bus encodings and small lane helpers for the SRAM responder.
package vscale_hasti_sram_slave_pkg;

    localparam int HASTI_BUS_WIDTH  = 32;
    localparam int HASTI_ADDR_WIDTH = 32;
    localparam int HASTI_BUS_NBYTES = HASTI_BUS_WIDTH / 8;

    localparam logic [2:0] HASTI_SIZE_BYTE     = 3'd0;
    localparam logic [2:0] HASTI_SIZE_HALFWORD = 3'd1;
    localparam logic [2:0] HASTI_SIZE_WORD     = 3'd2;

    localparam logic HASTI_RESP_OKAY  = 1'b0;
    localparam logic HASTI_RESP_ERROR = 1'b1;

    // Byte-lane enables for an aligned access of the given size at the given offset.
    function automatic logic [HASTI_BUS_NBYTES-1:0] byte_enables(
        input logic [2:0] size,
        input logic [1:0] offset
    );
        logic [HASTI_BUS_NBYTES-1:0] be;
        case (size)
            HASTI_SIZE_BYTE:     be = 4'b0001 << offset;
            HASTI_SIZE_HALFWORD: be = 4'b0011 << offset;
            default:             be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replace the lanes of base selected by be with the matching lanes of upd.
    function automatic logic [HASTI_BUS_WIDTH-1:0] merge_lanes(
        input logic [HASTI_BUS_WIDTH-1:0]  base,
        input logic [HASTI_BUS_WIDTH-1:0]  upd,
        input logic [HASTI_BUS_NBYTES-1:0] be
    );
        logic [HASTI_BUS_WIDTH-1:0] res;
        res = base;
        for (int b = 0; b < HASTI_BUS_NBYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = upd[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vscale_hasti_sram_slave_sram.sv
// Single-port word SRAM: synchronous read, byte-enable write, one access per cycle.
module vscale_sram_1rw
    import vscale_hasti_sram_slave_pkg::*;
#(
    parameter int NWORDS = 1024,
    parameter int AW     = 10
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic                        we,
    input  logic [AW-1:0]               addr,
    input  logic [HASTI_BUS_NBYTES-1:0] be,
    input  logic [HASTI_BUS_WIDTH-1:0]  wdata,
    output logic [HASTI_BUS_WIDTH-1:0]  rdata
);

    logic [HASTI_BUS_WIDTH-1:0] mem [NWORDS];

    // Array access: a write updates the enabled lanes, a read refreshes rdata.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < HASTI_BUS_NBYTES; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// AHB-Lite (HASTI) SRAM responder: address/data pipeline, wait states, ERROR response.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no data phase pending, hreadyout=1, OKAY
//  WAIT    | OKAY data phase being stretched, hreadyout=0
//  DATA    | final OKAY data-phase cycle, access completes here
//  ERR1    | first ERROR cycle, hreadyout=0
//  ERR2    | second ERROR cycle, hreadyout=1
//
// The array has a single port. When a write data phase coincides with a read
// being issued, the write is parked in a one-entry buffer and committed on the
// next free port cycle; reads merge in whatever write is newer than the array.
module vscale_hasti_sram_slave
    import vscale_hasti_sram_slave_pkg::*;
#(
    parameter int NWORDS      = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        hsel,
    input  logic [HASTI_ADDR_WIDTH-1:0] haddr,
    input  logic                        hwrite,
    input  logic [2:0]                  hsize,
    input  logic [2:0]                  hburst,
    input  logic                        hmastlock,
    input  logic [3:0]                  hprot,
    input  logic [1:0]                  htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]  hwdata,
    input  logic                        hready,
    output logic [HASTI_BUS_WIDTH-1:0]  hrdata,
    output logic                        hreadyout,
    output logic                        hresp
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [HASTI_ADDR_WIDTH-3:0] WORD_LIMIT = (HASTI_ADDR_WIDTH-2)'(NWORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic HAS_WAIT = (WAIT_STATES != 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;

    logic             accept, addr_bad, good_accept;
    logic [IDX_W-1:0] addr_idx;

    logic                        dp_write;
    logic [IDX_W-1:0]            dp_idx;
    logic [HASTI_BUS_NBYTES-1:0] dp_be;

    logic                        pw_valid;
    logic [IDX_W-1:0]            pw_idx;
    logic [HASTI_BUS_NBYTES-1:0] pw_be;
    logic [HASTI_BUS_WIDTH-1:0]  pw_data;

    logic                        src_valid;
    logic [IDX_W-1:0]            src_idx;
    logic [HASTI_BUS_NBYTES-1:0] src_be;
    logic [HASTI_BUS_WIDTH-1:0]  src_data;

    logic [HASTI_BUS_NBYTES-1:0] byp_be;
    logic [HASTI_BUS_WIDTH-1:0]  byp_data;
    logic [HASTI_BUS_WIDTH-1:0]  rdata_hold;

    logic             rd_issue, wr_now, read_done;
    logic [IDX_W-1:0] rd_idx;

    logic                        ram_en, ram_we;
    logic [IDX_W-1:0]            ram_addr;
    logic [HASTI_BUS_NBYTES-1:0] ram_be;
    logic [HASTI_BUS_WIDTH-1:0]  ram_wdata, ram_rdata, read_word;

    // Burst, lock and protection attributes do not change how a beat is served.
    logic unused_bus;
    assign unused_bus = ^{hburst, hmastlock, hprot, htrans[0]};

    // Address-phase decode; accepts only while this responder is not stretching.
    always_comb begin
        addr_idx    = haddr[IDX_W+1:2];
        accept      = hsel & htrans[1] & hready & hreadyout;
        addr_bad    = (haddr[HASTI_ADDR_WIDTH-1:2] >= WORD_LIMIT)
                    | (hsize > HASTI_SIZE_WORD)
                    | ((hsize == HASTI_SIZE_HALFWORD) & haddr[0])
                    | ((hsize == HASTI_SIZE_WORD) & (|haddr[1:0]));
        good_accept = accept & ~addr_bad;
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic and bus response outputs.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        hreadyout     = 1'b1;
        hresp         = HASTI_RESP_OKAY;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state == ST_ERR2) begin
                    hresp = HASTI_RESP_ERROR;
                end
                if (accept) begin
                    if (addr_bad) begin
                        state_next = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                hreadyout     = 1'b0;
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_next = ST_DATA;
                end
            end
            ST_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = HASTI_RESP_ERROR;
                state_next = ST_ERR2;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Data-phase attributes captured from a good address phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= '0;
        end else if (good_accept) begin
            dp_write <= hwrite;
            dp_idx   <= addr_idx;
            dp_be    <= byte_enables(hsize, haddr[1:0]);
        end
    end

    // Read launch point: at accept without wait states, else on the last WAIT cycle.
    always_comb begin
        wr_now    = (state == ST_DATA) & dp_write;
        read_done = (state == ST_DATA) & ~dp_write;
        rd_issue  = (good_accept & ~hwrite & ~HAS_WAIT)
                  | ((state == ST_WAIT) & (wait_cnt == 4'd1) & ~dp_write);
        rd_idx    = (state == ST_WAIT) ? dp_idx : addr_idx;
    end

    // Port arbitration: reads first, then the live write, then the parked write.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_idx;
        ram_be    = '0;
        ram_wdata = hwdata;
        if (rd_issue) begin
            ram_en = 1'b1;
        end else if (wr_now) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = dp_idx;
            ram_be   = dp_be;
        end else if (pw_valid) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = pw_idx;
            ram_be    = pw_be;
            ram_wdata = pw_data;
        end
    end

    // Park a write that lost the port to a read; drop it once committed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pw_valid <= 1'b0;
            pw_idx   <= '0;
            pw_be    <= '0;
            pw_data  <= '0;
        end else if (wr_now && rd_issue) begin
            pw_valid <= 1'b1;
            pw_idx   <= dp_idx;
            pw_be    <= dp_be;
            pw_data  <= hwdata;
        end else if (pw_valid && !rd_issue && !wr_now) begin
            pw_valid <= 1'b0;
        end
    end

    // The newest write not yet visible in the array when a read launches.
    always_comb begin
        if (wr_now) begin
            src_valid = 1'b1;
            src_idx   = dp_idx;
            src_be    = dp_be;
            src_data  = hwdata;
        end else begin
            src_valid = pw_valid;
            src_idx   = pw_idx;
            src_be    = pw_be;
            src_data  = pw_data;
        end
    end

    // Snapshot the bypass lanes alongside the array read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_be   <= '0;
            byp_data <= '0;
        end else if (rd_issue) begin
            byp_be   <= (src_valid && (src_idx == rd_idx)) ? src_be : '0;
            byp_data <= src_data;
        end
    end

    assign read_word = merge_lanes(ram_rdata, byp_data, byp_be);

    // Hold the last completed read so hrdata is stable between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_hold <= '0;
        end else if (read_done) begin
            rdata_hold <= read_word;
        end
    end

    assign hrdata = read_done ? read_word : rdata_hold;

    vscale_sram_1rw #(
        .NWORDS (NWORDS),
        .AW     (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Bench for the HASTI SRAM responder: one instance without and one with wait states.
module tb_vscale_hasti_sram_slave;

    localparam int NWORDS = 1024;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready_low;
    logic        dut_sel;
    logic        mon_en;

    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;
    logic        ready0, ready3, sel0, sel3;
    logic        hready_cur, mon_ready, mon_resp;
    logic [31:0] mon_rdata;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[28];
    exp_t sb[$];
    exp_t cur;
    logic dp_active = 1'b0;
    logic err1_seen = 1'b0;
    int   stalls = 0;

    assign ready0     = hreadyout0 & ~hready_low;
    assign ready3     = hreadyout3 & ~hready_low;
    assign sel0       = hsel & ~dut_sel;
    assign sel3       = hsel & dut_sel;
    assign hready_cur = dut_sel ? ready3 : ready0;
    assign mon_ready  = dut_sel ? hreadyout3 : hreadyout0;
    assign mon_resp   = dut_sel ? hresp3 : hresp0;
    assign mon_rdata  = dut_sel ? hrdata3 : hrdata0;

    always #5 clk = ~clk;

    vscale_hasti_sram_slave #(.NWORDS(NWORDS), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .hsel(sel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans),
        .hwdata(hwdata), .hready(ready0), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
    );

    vscale_hasti_sram_slave #(.NWORDS(NWORDS), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .hsel(sel3), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans),
        .hwdata(hwdata), .hready(ready3), .hrdata(hrdata3), .hreadyout(hreadyout3), .hresp(hresp3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                                input logic err, input logic chk, input logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.addr = a; v.size = sz;
        v.wdata = wd; v.exp_err = err; v.chk = chk; v.exp_rdata = rd;
        return v;
    endfunction

    // Drive one address phase, hold it until accepted, then present its write data.
    task automatic run_vec(input vec_t v);
        int   guard;
        logic acc;
        exp_t e;
        hsel = v.sel; htrans = v.trans; hwrite = v.wr; haddr = v.addr; hsize = v.size;
        guard = 0;
        @(negedge clk);
        while (!hready_cur && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!hready_cur) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: hready still %0b after %0d cycles, required 1", hready_cur, guard);
        end
        acc = v.sel & v.trans[1] & hready_cur;
        if (acc) begin
            e.wr = v.wr; e.err = v.exp_err; e.chk = v.chk; e.rdata = v.exp_rdata;
            e.stall = v.exp_err ? 1 : (dut_sel ? 3 : 0);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (acc && v.wr) hwdata = v.wdata;
    endtask

    task automatic drain();
        int guard;
        hsel = 1'b0; htrans = 2'b00;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: %0d transfers outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard side: follow each accepted transfer to completion and compare.
    always @(negedge clk) begin
        if (!reset_n || !mon_en) begin
            dp_active = 1'b0;
        end else begin
            if (dp_active) begin
                if (mon_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL sb_underflow: got empty queue, required one expected transfer");
                    end else begin
                        cur = sb.pop_front();
                        check("hresp", 32'(mon_resp), 32'(cur.err));
                        check("wait_cycles", 32'(stalls), 32'(cur.stall));
                        if (cur.err) check("err_first_cycle", 32'(err1_seen), 32'd1);
                        if (!cur.wr && !cur.err && cur.chk) check("hrdata", mon_rdata, cur.rdata);
                    end
                    dp_active = 1'b0;
                end else begin
                    if (stalls == 0) err1_seen = mon_resp;
                    stalls++;
                end
            end else begin
                check("idle_resp", 32'({mon_ready, mon_resp}), 32'h2);
            end
            if (hsel && htrans[1] && hready_cur) begin
                dp_active = 1'b1;
                stalls    = 0;
                err1_seen = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        // sel trans wr addr size wdata err chk rdata
        vecs[0]  = mk(1, 2'b10, 1, 32'h10,   3'd2, 32'h11111111, 0, 0, 32'h0);
        vecs[1]  = mk(1, 2'b10, 1, 32'h04,   3'd2, 32'h12345678, 0, 0, 32'h0);
        vecs[2]  = mk(1, 2'b10, 0, 32'h04,   3'd2, 32'h0,        0, 1, 32'h12345678);
        vecs[3]  = mk(1, 2'b10, 1, 32'h08,   3'd2, 32'h00000000, 0, 0, 32'h0);
        vecs[4]  = mk(1, 2'b10, 1, 32'h09,   3'd0, 32'h0000AB00, 0, 0, 32'h0);
        vecs[5]  = mk(1, 2'b11, 1, 32'h0A,   3'd1, 32'hCDEF0000, 0, 0, 32'h0);
        vecs[6]  = mk(1, 2'b10, 0, 32'h08,   3'd2, 32'h0,        0, 1, 32'hCDEFAB00);
        vecs[7]  = mk(1, 2'b00, 0, 32'h00,   3'd2, 32'h0,        0, 0, 32'h0);
        vecs[8]  = mk(1, 2'b10, 0, 32'h08,   3'd2, 32'h0,        0, 1, 32'hCDEFAB00);
        vecs[9]  = mk(1, 2'b10, 0, 32'h02,   3'd2, 32'h0,        1, 0, 32'h0);
        vecs[10] = mk(1, 2'b10, 0, 32'h01,   3'd1, 32'h0,        1, 0, 32'h0);
        vecs[11] = mk(1, 2'b10, 0, 32'h1000, 3'd2, 32'h0,        1, 0, 32'h0);
        vecs[12] = mk(1, 2'b10, 1, 32'h0C,   3'd2, 32'h55AA55AA, 0, 0, 32'h0);
        vecs[13] = mk(1, 2'b10, 1, 32'h0D,   3'd2, 32'hFFFFFFFF, 1, 0, 32'h0);
        vecs[14] = mk(1, 2'b10, 1, 32'h0C,   3'd3, 32'h00000000, 1, 0, 32'h0);
        vecs[15] = mk(1, 2'b10, 0, 32'h0C,   3'd2, 32'h0,        0, 1, 32'h55AA55AA);
        vecs[16] = mk(1, 2'b00, 1, 32'h08,   3'd2, 32'h0,        0, 0, 32'h0);
        vecs[17] = mk(1, 2'b01, 1, 32'h08,   3'd2, 32'h0,        0, 0, 32'h0);
        vecs[18] = mk(0, 2'b10, 1, 32'h08,   3'd2, 32'h0,        0, 0, 32'h0);
        vecs[19] = mk(1, 2'b10, 0, 32'h08,   3'd2, 32'h0,        0, 1, 32'hCDEFAB00);
        vecs[20] = mk(1, 2'b10, 0, 32'h08,   3'd2, 32'h0,        0, 1, 32'hCDEFAB00);
        vecs[21] = mk(1, 2'b10, 0, 32'h0B,   3'd0, 32'h0,        0, 1, 32'hCDEFAB00);
        vecs[22] = mk(1, 2'b10, 1, 32'h00,   3'd2, 32'hA5A5A5A5, 0, 0, 32'h0);
        vecs[23] = mk(1, 2'b10, 0, 32'h00,   3'd2, 32'h0,        0, 1, 32'hA5A5A5A5);
        vecs[24] = mk(1, 2'b10, 0, 32'h02,   3'd2, 32'h0,        1, 0, 32'h0);
        vecs[25] = mk(1, 2'b00, 0, 32'h00,   3'd2, 32'h0,        0, 0, 32'h0);
        vecs[26] = mk(1, 2'b10, 0, 32'h00,   3'd2, 32'h0,        0, 1, 32'hA5A5A5A5);
        vecs[27] = mk(1, 2'b10, 0, 32'h10,   3'd2, 32'h0,        0, 1, 32'h11111111);

        reset_n = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
        htrans = 2'b00; hwdata = '0; hready_low = 1'b0; dut_sel = 1'b0; mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp0", 32'({hreadyout0, hresp0}), 32'h2);
        check("reset_rdata0", hrdata0, 32'h0);
        check("reset_resp3", 32'({hreadyout3, hresp3}), 32'h2);
        check("reset_rdata3", hrdata3, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // No wait states: back-to-back, byte lanes, errors, ignored address phases.
        for (int i = 0; i <= 19; i++) run_vec(vecs[i]);
        drain();

        // Bus hready low: a NONSEQ write must not be taken.
        hready_low = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h08; hsize = 3'd2;
        hwdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hready_low = 1'b0;
        check("hready_low_rdata", hrdata0, 32'hCDEFAB00);
        for (int i = 20; i <= 21; i++) run_vec(vecs[i]);
        drain();

        // Reset in the data phase of a write discards it.
        mon_en = 1'b0;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hsel = 1'b0; htrans = 2'b00;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_resp", 32'({hreadyout0, hresp0}), 32'h2);
        check("midreset_rdata", hrdata0, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_vec(vecs[27]);
        drain();

        // Three wait states, including an error followed by IDLE during ERR1.
        dut_sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 22; i <= 26; i++) run_vec(vecs[i]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
